// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller with return-address stack and RUN/HALT FSM.
// Ports: clk, reset (sync, active-high); pc_cur, control-flow requests
//        (stall, jump, branch, call, ret) and their targets/offset in;
//        pc_next (combinational), depth, halted, fault out.
module pc_sequencer #(
    parameter int          STACK_DEPTH = 4,
    parameter logic [7:0]  RESET_PC    = 8'd0,
    localparam int         DW          = $clog2(STACK_DEPTH + 1),
    localparam int         AW          = $clog2(STACK_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    pc_cur,
    input  logic          stall,
    input  logic          jump,
    input  logic [7:0]    jump_target,
    input  logic          branch,
    input  logic          branch_cond,
    input  logic [7:0]    branch_offset,
    input  logic          call,
    input  logic [7:0]    call_target,
    input  logic          ret,
    output logic [7:0]    pc_next,
    output logic [DW-1:0] depth,
    output logic          halted,
    output logic [1:0]    fault
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [1:0] F_NONE  = 2'b00;
    localparam logic [1:0] F_OVER  = 2'b01;
    localparam logic [1:0] F_UNDER = 2'b10;

    state_t        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [1:0]    fault_q, fault_d;
    logic [7:0]    stack_q [STACK_DEPTH];
    logic          push;

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [7:0]    pc_inc;

    assign wr_idx = depth_q[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);
    assign pc_inc = pc_cur + 8'd1;

    always_comb begin
        pc_next = pc_inc;
        state_d = state_q;
        depth_d = depth_q;
        fault_d = fault_q;
        push    = 1'b0;
        if (reset) begin
            pc_next = RESET_PC;
        end else if (state_q == HALT) begin
            pc_next = pc_cur;
        end else if (stall) begin
            pc_next = pc_cur;
        end else if (ret) begin
            if (depth_q == '0) begin
                pc_next = pc_cur;
                fault_d = F_UNDER;
                state_d = HALT;
            end else begin
                pc_next = stack_q[rd_idx];
                depth_d = depth_q - DW'(1);
            end
        end else if (call) begin
            if (depth_q == DW'(STACK_DEPTH)) begin
                pc_next = pc_cur;
                fault_d = F_OVER;
                state_d = HALT;
            end else begin
                pc_next = call_target;
                push    = 1'b1;
                depth_d = depth_q + DW'(1);
            end
        end else if (jump) begin
            pc_next = jump_target;
        end else if (branch && branch_cond) begin
            // 8-bit add of the raw offset equals sign-extended add mod 256
            pc_next = pc_cur + branch_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            depth_q <= '0;
            fault_q <= F_NONE;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            fault_q <= fault_d;
        end
    end

    // Entries are never cleared; only depth marks what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end

    assign depth  = depth_q;
    assign halted = (state_q == HALT);
    assign fault  = fault_q;

endmodule
